// File: rtl/jpeg_enc_pkg.sv
// Shared constants and address helpers for the JPEG encoder front end.
// Block geometry defaults match the baseline 8x8 DCT block.
package jpeg_enc_pkg;

   localparam int JPEG_DATA_WIDTH  = 8;
   localparam int JPEG_BLOCK_W     = 8;
   localparam int JPEG_BLOCK_H     = 8;
   localparam int JPEG_BLOCK_DEPTH = JPEG_BLOCK_W * JPEG_BLOCK_H;

   // Beat index k of a column-major stream lands at row k%H, column k/H.
   function automatic logic [5:0] raster_to_col_addr(input logic [5:0] idx);
      return {idx[2:0], idx[5:3]};
   endfunction

endpackage

// File: rtl/jpeg_block_bank.sv
// One block of sample storage: single-sample write, whole-block write,
// and the full block presented as a packed bus with sample 0 in the MSBs.
module jpeg_block_bank
   import jpeg_enc_pkg::*;
#(
   parameter int  DATA_WIDTH = JPEG_DATA_WIDTH,
   parameter int  DEPTH      = JPEG_BLOCK_DEPTH,
   localparam int IDX_W      = $clog2(DEPTH)
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        wr_en_i,
   input  logic [IDX_W-1:0]            wr_addr_i,
   input  logic [DATA_WIDTH-1:0]       wr_data_i,
   input  logic                        blk_we_i,
   input  logic [DATA_WIDTH*DEPTH-1:0] blk_data_i,
   output logic [DATA_WIDTH*DEPTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (blk_we_i) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= blk_data_i[DATA_WIDTH*(DEPTH-i)-1 -: DATA_WIDTH];
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_rd
      assign rd_data_o[DATA_WIDTH*(DEPTH-g)-1 -: DATA_WIDTH] = mem_q[g];
   end

endmodule

// File: rtl/jpeg_block_pingpong_buffer.sv
// Ping-pong block buffer: fills one bank per pixel or per whole block while
// the other bank is presented downstream as a packed block.
module jpeg_block_pingpong_buffer
   import jpeg_enc_pkg::*;
#(
   parameter int  DATA_WIDTH = JPEG_DATA_WIDTH,
   parameter int  BLOCK_W    = JPEG_BLOCK_W,
   parameter int  BLOCK_H    = JPEG_BLOCK_H,
   localparam int DEPTH      = BLOCK_W * BLOCK_H,
   localparam int IDX_W      = $clog2(DEPTH)
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        flush,
   input  logic                        transpose_en,
   input  logic                        pix_valid,
   output logic                        pix_ready,
   input  logic [DATA_WIDTH-1:0]       pix_data,
   input  logic                        blk_valid,
   output logic                        blk_ready,
   input  logic [DATA_WIDTH*DEPTH-1:0] blk_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH*DEPTH-1:0] out_data,
   output logic                        out_transposed,
   output logic [1:0]                  level,
   output logic [IDX_W:0]              fill_count
);

   logic [1:0]     full_q, full_d;
   logic [1:0]     tbit_q, tbit_d;
   logic           wr_bank_q, wr_bank_d;
   logic           rd_bank_q, rd_bank_d;
   logic           cur_tr_q, cur_tr_d;
   logic [IDX_W:0] fill_count_q, fill_count_d;
   logic [1:0]     level_q, level_d;

   logic             blk_acc, pix_acc, out_acc, last_beat, complete, tr_cur;
   logic [IDX_W-1:0] fill_lo, col_addr, wr_addr;
   logic [DATA_WIDTH*DEPTH-1:0] bank_rd [2];

   assign blk_ready = !full_q[wr_bank_q] && (fill_count_q == '0);
   assign pix_ready = !full_q[wr_bank_q] && !(blk_valid && blk_ready);

   // flush suppresses every handshake in its cycle
   assign blk_acc = blk_valid && blk_ready && !flush;
   assign pix_acc = pix_valid && pix_ready && !flush;
   assign out_acc = out_valid && out_ready && !flush;

   // Write order is frozen at the first pixel of a block.
   assign tr_cur    = (fill_count_q == '0) ? transpose_en : cur_tr_q;
   assign fill_lo   = fill_count_q[IDX_W-1:0];
   assign col_addr  = (fill_lo % IDX_W'(BLOCK_H)) * IDX_W'(BLOCK_W) + fill_lo / IDX_W'(BLOCK_H);
   assign wr_addr   = tr_cur ? col_addr : fill_lo;
   assign last_beat = pix_acc && (fill_count_q == (IDX_W+1)'(DEPTH-1));
   assign complete  = last_beat || blk_acc;

   always_comb begin
      full_d       = full_q;
      tbit_d       = tbit_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      cur_tr_d     = cur_tr_q;
      fill_count_d = fill_count_q;
      if (flush) begin
         full_d       = '0;
         wr_bank_d    = 1'b0;
         rd_bank_d    = 1'b0;
         fill_count_d = '0;
      end else begin
         if (out_acc) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
         end
         if (complete) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
         end
         if (blk_acc) tbit_d[wr_bank_q] = 1'b0;
         if (pix_acc) begin
            cur_tr_d = tr_cur;
            if (fill_count_q == '0) tbit_d[wr_bank_q] = transpose_en;
            fill_count_d = last_beat ? '0 : fill_count_q + 1'b1;
         end
      end
      level_d = {1'b0, full_d[0]} + {1'b0, full_d[1]};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         full_q       <= '0;
         tbit_q       <= '0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         cur_tr_q     <= 1'b0;
         fill_count_q <= '0;
         level_q      <= '0;
      end else begin
         full_q       <= full_d;
         tbit_q       <= tbit_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         cur_tr_q     <= cur_tr_d;
         fill_count_q <= fill_count_d;
         level_q      <= level_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      jpeg_block_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_bank (
         .clock      (clock),
         .reset_n    (reset_n),
         .wr_en_i    (pix_acc && (wr_bank_q == 1'(b))),
         .wr_addr_i  (wr_addr),
         .wr_data_i  (pix_data),
         .blk_we_i   (blk_acc && (wr_bank_q == 1'(b))),
         .blk_data_i (blk_data),
         .rd_data_o  (bank_rd[b])
      );
   end

   assign out_valid      = full_q[rd_bank_q];
   assign out_data       = bank_rd[rd_bank_q];
   assign out_transposed = tbit_q[rd_bank_q];
   assign level          = level_q;
   assign fill_count     = fill_count_q;

endmodule

// File: tb/tb_jpeg_block_pingpong_buffer.sv
// Randomised and directed bench for the ping-pong block buffer, checked
// every cycle against a queue-of-blocks model.
module tb_jpeg_block_pingpong_buffer;

   localparam int DW = 8;
   localparam int D  = 64;
   localparam int BW = DW * D;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush = 1'b0;
   logic          transpose_en = 1'b0;
   logic          pix_valid = 1'b0;
   logic [DW-1:0] pix_data = '0;
   logic          blk_valid = 1'b0;
   logic [BW-1:0] blk_data = '0;
   logic          out_ready = 1'b0;
   logic          pix_ready, blk_ready, out_valid, out_transposed;
   logic [BW-1:0] out_data;
   logic [1:0]    level;
   logic [6:0]    fill_count;

   jpeg_block_pingpong_buffer dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .flush          (flush),
      .transpose_en   (transpose_en),
      .pix_valid      (pix_valid),
      .pix_ready      (pix_ready),
      .pix_data       (pix_data),
      .blk_valid      (blk_valid),
      .blk_ready      (blk_ready),
      .blk_data       (blk_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_transposed (out_transposed),
      .level          (level),
      .fill_count     (fill_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   // Model: partially filled block in raster beat order, plus FIFO of completed blocks.
   logic [DW-1:0] m_part [D];
   int            m_cnt = 0;
   bit            m_tr = 1'b0;
   logic [BW-1:0] m_q [$];
   bit            m_qtr [$];
   bit            m_pix_acc, m_blk_acc;

   function automatic void chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   function automatic void fail_timeout(string name);
      checks++;
      failures++;
      $display("FAIL %s timed out waiting for handshake", name);
   endfunction

   function automatic void model_clear();
      m_q.delete();
      m_qtr.delete();
      m_cnt = 0;
   endfunction

   // A column-major block is the matrix transpose of the same beats laid out in raster order.
   function automatic logic [BW-1:0] assemble();
      logic [BW-1:0] b;
      b = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            b[BW-1-(r*8+c)*DW -: DW] = m_tr ? m_part[c*8+r] : m_part[r*8+c];
      return b;
   endfunction

   function automatic bit exp_blk_ready();
      return (m_q.size() < 2) && (m_cnt == 0);
   endfunction

   function automatic bit exp_pix_ready();
      return (m_q.size() < 2) && !(blk_valid && exp_blk_ready());
   endfunction

   function automatic void model_update();
      bit out_acc;
      m_pix_acc = 1'b0;
      m_blk_acc = 1'b0;
      if (flush) begin
         model_clear();
         return;
      end
      m_blk_acc = blk_valid && exp_blk_ready();
      m_pix_acc = pix_valid && exp_pix_ready();
      out_acc   = out_ready && (m_q.size() > 0);
      if (out_acc) begin
         m_q.delete(0);
         m_qtr.delete(0);
      end
      if (m_blk_acc) begin
         m_q.push_back(blk_data);
         m_qtr.push_back(1'b0);
      end
      if (m_pix_acc) begin
         if (m_cnt == 0) m_tr = transpose_en;
         m_part[m_cnt] = pix_data;
         m_cnt++;
         if (m_cnt == D) begin
            m_q.push_back(assemble());
            m_qtr.push_back(m_tr);
            m_cnt = 0;
         end
      end
   endfunction

   always @(negedge clock) begin
      if (chk_en && reset_n) begin
         chk("pix_ready",  512'(pix_ready),  512'(exp_pix_ready()));
         chk("blk_ready",  512'(blk_ready),  512'(exp_blk_ready()));
         chk("out_valid",  512'(out_valid),  512'(m_q.size() > 0));
         chk("level",      512'(level),      512'(m_q.size()));
         chk("fill_count", 512'(fill_count), 512'(m_cnt));
         if (m_q.size() > 0) begin
            chk("out_data",       out_data,             m_q[0]);
            chk("out_transposed", 512'(out_transposed), 512'(m_qtr[0]));
         end
      end
   end

   task automatic cycle();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic send_pix(input logic [DW-1:0] v, input bit tr);
      bit done = 1'b0;
      pix_valid    = 1'b1;
      pix_data     = v;
      transpose_en = tr;
      for (int t = 0; t < 300 && !done; t++) begin
         cycle();
         done = m_pix_acc;
      end
      pix_valid = 1'b0;
      if (!done) fail_timeout("send_pix");
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int t = 0; t < 10 && m_q.size() > 0; t++) cycle();
      out_ready = 1'b0;
      if (m_q.size() > 0) fail_timeout("drain");
   endtask

   task automatic do_flush();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
   endtask

   initial begin
      int ncyc;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_out_valid",      512'(out_valid),      512'(0));
      chk("rst_level",          512'(level),          512'(0));
      chk("rst_fill_count",     512'(fill_count),     512'(0));
      chk("rst_out_data",       out_data,             512'(0));
      chk("rst_out_transposed", 512'(out_transposed), 512'(0));
      reset_n = 1'b1;
      model_clear();
      chk_en = 1'b1;
      cycle();

      // raster fill
      for (int k = 0; k < 64; k++) send_pix(8'(k), 1'b0);
      chk("raster_valid", 512'(out_valid),           512'(1));
      chk("raster_s0",    512'(out_data[511:504]),   512'(0));
      chk("raster_s63",   512'(out_data[7:0]),       512'(63));
      chk("raster_level", 512'(level),               512'(1));
      drain();

      // column-major fill
      for (int k = 0; k < 64; k++) send_pix(8'(k), 1'b1);
      chk("trans_s1",   512'(out_data[511-1*8 -: 8]),  512'(8));
      chk("trans_s8",   512'(out_data[511-8*8 -: 8]),  512'(1));
      chk("trans_s63",  512'(out_data[511-63*8 -: 8]), 512'(63));
      chk("trans_flag", 512'(out_transposed),          512'(1));
      drain();

      // backpressure: both banks fill, then one release frees the writer
      for (int k = 0; k < 128; k++) send_pix(8'($urandom), 1'($urandom));
      pix_valid = 1'b1;
      pix_data  = 8'hC3;
      cycle();
      chk("bp_level",     512'(level),     512'(2));
      chk("bp_pix_ready", 512'(pix_ready), 512'(0));
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      chk("bp_release_level", 512'(level),     512'(1));
      chk("bp_release_ready", 512'(pix_ready), 512'(1));
      send_pix(8'hC3, 1'b0);
      send_pix(8'h3C, 1'b0);
      drain();
      do_flush();
      chk("flush_bp_valid", 512'(out_valid), 512'(0));

      // overlap: with the consumer always ready the writer never stalls
      out_ready = 1'b1;
      ncyc = 0;
      for (int k = 0; k < 192; k++) begin
         pix_valid = 1'b1;
         pix_data  = 8'($urandom);
         transpose_en = 1'($urandom);
         cycle();
         ncyc++;
         if (!m_pix_acc) begin
            pix_valid = 1'b1;
            cycle();
            ncyc++;
         end
      end
      pix_valid = 1'b0;
      chk("overlap_cycles", 512'(ncyc), 512'(192));
      cycle();
      out_ready = 1'b0;

      // block load against a same-cycle pixel
      blk_data  = {64{8'hA5}};
      blk_valid = 1'b1;
      pix_valid = 1'b1;
      pix_data  = 8'h11;
      transpose_en = 1'b0;
      cycle();
      blk_valid = 1'b0;
      chk("contend_fill",  512'(fill_count), 512'(0));
      chk("contend_level", 512'(level),      512'(1));
      chk("contend_data",  out_data,         {64{8'hA5}});
      cycle();
      pix_valid = 1'b0;
      chk("contend_pix_next", 512'(fill_count), 512'(1));
      drain();

      // flush mid-block, then a fresh block
      do_flush();
      for (int k = 0; k < 20; k++) send_pix(8'(200 + k), 1'b0);
      do_flush();
      chk("flush_fill", 512'(fill_count), 512'(0));
      for (int k = 0; k < 64; k++) send_pix(8'(100 + k), 1'b0);
      chk("flush_new_s0",  512'(out_data[511:504]), 512'(100));
      chk("flush_new_s63", 512'(out_data[7:0]),     512'(163));
      chk("flush_level",   512'(level),             512'(1));

      // reset mid-block with a full bank pending
      for (int k = 0; k < 10; k++) send_pix(8'(k + 1), 1'b1);
      chk_en  = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("mrst_out_valid",      512'(out_valid),      512'(0));
      chk("mrst_level",          512'(level),          512'(0));
      chk("mrst_fill_count",     512'(fill_count),     512'(0));
      chk("mrst_out_data",       out_data,             512'(0));
      chk("mrst_out_transposed", 512'(out_transposed), 512'(0));
      model_clear();
      @(posedge clock);
      #2;
      reset_n = 1'b1;
      chk_en  = 1'b1;
      cycle();

      // random traffic
      for (int t = 0; t < 4000; t++) begin
         pix_valid    = ($urandom_range(0, 9) < 7);
         pix_data     = 8'($urandom);
         transpose_en = 1'($urandom);
         blk_valid    = ($urandom_range(0, 39) == 0);
         for (int i = 0; i < 16; i++) blk_data[i*32 +: 32] = $urandom();
         out_ready    = 1'($urandom);
         flush        = ($urandom_range(0, 199) == 0);
         cycle();
      end
      pix_valid = 1'b0;
      blk_valid = 1'b0;
      flush     = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
